video_stats_uart: RTL and testbench

VIDEO_STATS_UART -- requirements
Module: video_stats_uart

---
 rtl/video_stats_pkg.sv | 58 +++++
 rtl/uart_tx_byte.sv | 94 +++++++++
 rtl/video_stats_uart.sv | 182 ++++++++++++++++++
 tb/tb_video_stats_uart.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_stats_pkg.sv
// rtl/video_stats_pkg.sv - shared constants, state encodings and message formatting for video_stats_uart
package video_stats_pkg;

    localparam int MSG_LEN = 14;

    localparam int PIX_W   = 12;
    localparam int FRAME_W = 16;
    localparam int DROP_W  = 8;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic {
        MSG_IDLE,
        MSG_SEND
    } msg_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Uppercase ASCII hex digit: '0'..'9' = 0x30.., 'A'..'F' = 0x41.. (0x37 + 10)
    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    // Byte idx of "FFFF WWW HHH\r\n"
    function automatic logic [7:0] msg_byte(
        input logic [3:0]         idx,
        input logic [FRAME_W-1:0] frame,
        input logic [PIX_W-1:0]   width,
        input logic [PIX_W-1:0]   height
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = hex_ascii(frame[15:12]);
            4'd1:    b = hex_ascii(frame[11:8]);
            4'd2:    b = hex_ascii(frame[7:4]);
            4'd3:    b = hex_ascii(frame[3:0]);
            4'd4:    b = ASCII_SP;
            4'd5:    b = hex_ascii(width[11:8]);
            4'd6:    b = hex_ascii(width[7:4]);
            4'd7:    b = hex_ascii(width[3:0]);
            4'd8:    b = ASCII_SP;
            4'd9:    b = hex_ascii(height[11:8]);
            4'd10:   b = hex_ascii(height[7:4]);
            4'd11:   b = hex_ascii(height[3:0]);
            4'd12:   b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 UART byte transmitter with back-to-back byte chaining
//
// Ports:
//   I_pxl_clk  clock
//   I_rst_n    asynchronous active-low reset
//   start      request to send byte_data; accepted when idle or in the final stop-bit cycle
//   byte_data  byte to send, captured on an accepted start
//   tx         serial line, idle high
//   done       high in the last cycle of the stop bit
module uart_tx_byte
    import video_stats_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       I_pxl_clk,
    input  logic       I_rst_n,
    input  logic       start,
    input  logic [7:0] byte_data,
    output logic       tx,
    output logic       done
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_q;
    tx_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             bit_end;
    logic             load;

    assign bit_end = (cnt_q == CNT_LAST);
    // A start during the last stop-bit cycle chains the next start bit with no idle gap
    assign load    = start && ((state_q == TX_IDLE) || done);

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:  if (start) state_d = TX_START;
            TX_START: if (bit_end) state_d = TX_DATA;
            TX_DATA:  if (bit_end && (bit_q == 3'd7)) state_d = TX_STOP;
            TX_STOP:  if (bit_end) state_d = start ? TX_START : TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        done = 1'b0;
        case (state_q)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = shift_q[0];
            TX_STOP:  done = bit_end;
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            if ((state_q == TX_IDLE) || bit_end) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (load) begin
                shift_q <= byte_data;
            end else if ((state_q == TX_DATA) && bit_end) begin
                shift_q <= {1'b0, shift_q[7:1]};
            end

            if (state_q == TX_START) begin
                bit_q <= '0;
            end else if ((state_q == TX_DATA) && bit_end) begin
                bit_q <= bit_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_stats_uart.sv
// rtl/video_stats_uart.sv - camera frame statistics with per-frame ASCII report over UART
//
// Ports:
//   I_pxl_clk     camera pixel clock
//   I_rst_n       asynchronous active-low reset
//   I_vs          vertical sync, active high
//   I_de          pixel valid
//   I_data        RGB565 pixel (not used)
//   O_uart_tx     UART 8N1 line, idle high
//   O_busy        message in progress
//   O_snap_valid  one-cycle pulse when a frame snapshot is latched
//   O_frame_cnt   completed frame count
//   O_width       last line width of last frame
//   O_height      line count of last frame
//   O_drop_cnt    snapshots not reported because a message was in progress
module video_stats_uart
    import video_stats_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 84_000_000,
    parameter int BAUD        = 115_200
) (
    input  logic               I_pxl_clk,
    input  logic               I_rst_n,
    input  logic               I_vs,
    input  logic               I_de,
    input  logic [15:0]        I_data,
    output logic               O_uart_tx,
    output logic               O_busy,
    output logic               O_snap_valid,
    output logic [FRAME_W-1:0] O_frame_cnt,
    output logic [PIX_W-1:0]   O_width,
    output logic [PIX_W-1:0]   O_height,
    output logic [DROP_W-1:0]  O_drop_cnt
);

    localparam int         CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam logic [3:0] LAST_IDX     = 4'(MSG_LEN - 1);

    logic data_unused;
    assign data_unused = ^I_data;

    logic               vs_q, vs_d, vs_arm_q;
    logic               de_q, de_d;
    logic               vs_rise, de_rise, de_fall;
    logic [PIX_W-1:0]   pix_cnt_q, line_w_q, line_cnt_q;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic [PIX_W-1:0]   width_q, height_q;
    logic               snap_q;
    logic [DROP_W-1:0]  drop_q;

    msg_state_t         msg_state_q, msg_state_d;
    logic [3:0]         idx_q;
    logic [FRAME_W-1:0] p_frame_q;
    logic [PIX_W-1:0]   p_width_q, p_height_q;
    logic               msg_start_first;
    logic               tx_start, tx_done, tx_line;
    logic [7:0]         tx_byte;

    // vs_arm_q stays low until I_vs has been seen low, so a sync already high at
    // reset release is not taken as a frame boundary
    assign vs_rise = vs_q & ~vs_d & vs_arm_q;
    assign de_rise = de_q & ~de_d;
    assign de_fall = ~de_q & de_d;

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vs_q        <= 1'b0;
            vs_d        <= 1'b0;
            vs_arm_q    <= 1'b0;
            de_q        <= 1'b0;
            de_d        <= 1'b0;
            pix_cnt_q   <= '0;
            line_w_q    <= '0;
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            width_q     <= '0;
            height_q    <= '0;
            snap_q      <= 1'b0;
            drop_q      <= '0;
        end else begin
            vs_q     <= I_vs;
            vs_d     <= vs_q;
            vs_arm_q <= vs_arm_q | ~I_vs;
            de_q     <= I_de;
            de_d     <= de_q;

            if (de_fall) begin
                line_w_q  <= pix_cnt_q;
                pix_cnt_q <= '0;
            end else if (de_q && (pix_cnt_q != '1)) begin
                pix_cnt_q <= pix_cnt_q + 1'b1;
            end

            // A line starting in the same cycle as the frame boundary belongs to the new frame
            if (vs_rise) begin
                line_cnt_q <= de_rise ? PIX_W'(1) : '0;
            end else if (de_rise && (line_cnt_q != '1)) begin
                line_cnt_q <= line_cnt_q + 1'b1;
            end

            snap_q <= vs_rise;
            if (vs_rise) begin
                width_q     <= line_w_q;
                height_q    <= line_cnt_q;
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end

            if (snap_q && (msg_state_q == MSG_SEND) && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    // The first byte is launched straight from the live snapshot in the snap cycle so
    // the start bit lines up with O_busy rising
    assign msg_start_first = snap_q && (msg_state_q == MSG_IDLE);

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            msg_state_q <= MSG_IDLE;
        end else begin
            msg_state_q <= msg_state_d;
        end
    end

    always_comb begin
        msg_state_d = msg_state_q;
        case (msg_state_q)
            MSG_IDLE: if (msg_start_first) msg_state_d = MSG_SEND;
            MSG_SEND: if (tx_done && (idx_q == LAST_IDX)) msg_state_d = MSG_IDLE;
            default:  msg_state_d = MSG_IDLE;
        endcase
    end

    always_comb begin
        O_busy   = (msg_state_q == MSG_SEND);
        tx_start = msg_start_first ||
                   ((msg_state_q == MSG_SEND) && tx_done && (idx_q != LAST_IDX));
        tx_byte  = (msg_state_q == MSG_IDLE) ?
                   msg_byte(4'd0, frame_cnt_q, width_q, height_q) :
                   msg_byte(idx_q + 4'd1, p_frame_q, p_width_q, p_height_q);
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            idx_q      <= '0;
            p_frame_q  <= '0;
            p_width_q  <= '0;
            p_height_q <= '0;
        end else begin
            if (msg_state_q == MSG_IDLE) begin
                idx_q <= '0;
            end else if (tx_done) begin
                idx_q <= idx_q + 1'b1;
            end
            if (msg_start_first) begin
                p_frame_q  <= frame_cnt_q;
                p_width_q  <= width_q;
                p_height_q <= height_q;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .I_pxl_clk (I_pxl_clk),
        .I_rst_n   (I_rst_n),
        .start     (tx_start),
        .byte_data (tx_byte),
        .tx        (tx_line),
        .done      (tx_done)
    );

    assign O_uart_tx    = tx_line;
    assign O_snap_valid = snap_q;
    assign O_frame_cnt  = frame_cnt_q;
    assign O_width      = width_q;
    assign O_height     = height_q;
    assign O_drop_cnt   = drop_q;

endmodule

// File: tb/tb_video_stats_uart.sv
// tb/tb_video_stats_uart.sv - scoreboard testbench for video_stats_uart
module tb_video_stats_uart;

    localparam int CPB     = 16;
    localparam int MSG_CYC = 14 * 10 * CPB;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs    = 1'b0;
    logic        de    = 1'b0;
    logic [15:0] data  = 16'h0;
    logic        uart_tx, busy, snap_valid;
    logic [15:0] frame_cnt;
    logic [11:0] width, height;
    logic [7:0]  drop_cnt;

    video_stats_uart #(
        .CLK_FREQ_HZ(16),
        .BAUD       (1)
    ) dut (
        .I_pxl_clk   (clk),
        .I_rst_n     (rst_n),
        .I_vs        (vs),
        .I_de        (de),
        .I_data      (data),
        .O_uart_tx   (uart_tx),
        .O_busy      (busy),
        .O_snap_valid(snap_valid),
        .O_frame_cnt (frame_cnt),
        .O_width     (width),
        .O_height    (height),
        .O_drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] frame;
        logic [11:0] width;
        logic [11:0] height;
    } snap_t;

    snap_t      exp_snap[$];
    logic [7:0] exp_bytes[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    string      hx       = "0123456789ABCDEF";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_hex(input int v, input int ndig);
        for (int i = ndig - 1; i >= 0; i--) exp_bytes.push_back(hx[(v >> (4 * i)) & 15]);
    endtask

    task automatic push_frame(input int f, input int w, input int h, input bit with_msg);
        snap_t s;
        s.frame  = f[15:0];
        s.width  = w[11:0];
        s.height = h[11:0];
        exp_snap.push_back(s);
        if (with_msg) begin
            push_hex(f, 4);
            exp_bytes.push_back(8'h20);
            push_hex(w, 3);
            exp_bytes.push_back(8'h20);
            push_hex(h, 3);
            exp_bytes.push_back(8'h0D);
            exp_bytes.push_back(8'h0A);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic line(input int n);
        de = 1'b1;
        cyc(n);
        de = 1'b0;
        cyc(2);
    endtask

    task automatic vs_pulse();
        vs = 1'b1;
        cyc(3);
        vs = 1'b0;
        cyc(3);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 3 * MSG_CYC) begin
            cyc(1);
            k++;
        end
        check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Snapshot monitor
    initial begin : snap_mon
        snap_t s;
        forever begin
            @(negedge clk);
            if (rst_n && snap_valid) begin
                if (exp_snap.size() == 0) begin
                    check("unexpected_snap", {16'd0, frame_cnt}, 32'hFFFF_FFFF);
                end else begin
                    s = exp_snap.pop_front();
                    check("snap_frame", {16'd0, frame_cnt}, {16'd0, s.frame});
                    check("snap_width", {20'd0, width}, {20'd0, s.width});
                    check("snap_height", {20'd0, height}, {20'd0, s.height});
                end
            end
        end
    end

    // UART decoder: samples mid-bit, discards a byte interrupted by reset
    initial begin : uart_mon
        logic [7:0] b;
        logic       stop_bit, start_ok, ok;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && (uart_tx == 1'b0)) begin
                ok = 1'b1;
                repeat (CPB / 2) @(negedge clk);
                if (!rst_n) ok = 1'b0;
                start_ok = (uart_tx == 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    if (!rst_n) ok = 1'b0;
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                if (!rst_n) ok = 1'b0;
                stop_bit = uart_tx;
                if (ok) begin
                    check("uart_start_bit", {31'd0, start_ok}, 32'd1);
                    check("uart_stop_bit", {31'd0, stop_bit}, 32'd1);
                    if (exp_bytes.size() == 0) begin
                        check("unexpected_uart_byte", {24'd0, b}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_bytes.pop_front();
                        check("uart_byte", {24'd0, b}, {24'd0, e});
                    end
                end
            end
        end
    end

    // Busy duration monitor
    initial begin : busy_mon
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0;
            end else if (busy) begin
                cnt++;
            end else if (cnt != 0) begin
                check("busy_cycles", cnt, MSG_CYC);
                cnt = 0;
            end
        end
    end

    initial begin : stim
        cyc(3);
        check("rst_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame", {16'd0, frame_cnt}, 32'd0);
        check("rst_drop", {24'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Frame 1: 3 lines x 5 pixels
        repeat (3) line(5);
        push_frame(1, 5, 3, 1'b1);
        vs_pulse();

        // Frame 2 arrives while frame 1 is being sent
        repeat (2) line(10);
        push_frame(2, 10, 2, 1'b0);
        vs_pulse();
        cyc(2);
        check("drop_after_f2", {24'd0, drop_cnt}, 32'd1);
        check("busy_during_f2", {31'd0, busy}, 32'd1);
        wait_idle();

        // Width saturation
        line(5000);
        push_frame(3, 12'hFFF, 1, 1'b1);
        vs_pulse();
        wait_idle();

        // Height saturation
        repeat (4100) line(1);
        push_frame(4, 1, 12'hFFF, 1'b1);
        vs_pulse();
        wait_idle();

        // Zero-line frame keeps previous width
        push_frame(5, 1, 0, 1'b1);
        vs_pulse();
        wait_idle();

        // Frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        cyc(1);
        release dut.frame_cnt_q;
        cyc(1);
        push_frame(0, 1, 0, 1'b1);
        vs_pulse();
        wait_idle();

        // Reset during byte 5 data bits
        push_frame(1, 1, 0, 1'b1);
        vs_pulse();
        cyc(840);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_snap", {31'd0, snap_valid}, 32'd0);
        check("mid_rst_frame", {16'd0, frame_cnt}, 32'd0);
        check("mid_rst_width", {20'd0, width}, 32'd0);
        check("mid_rst_height", {20'd0, height}, 32'd0);
        check("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
        exp_bytes.delete();
        vs = 1'b1;
        cyc(20);
        rst_n = 1'b1;
        cyc(200);
        check("vs_high_release_frame", {16'd0, frame_cnt}, 32'd0);
        check("vs_high_release_tx", {31'd0, uart_tx}, 32'd1);
        vs = 1'b0;
        cyc(3);
        line(7);
        push_frame(1, 7, 1, 1'b1);
        vs_pulse();
        wait_idle();
        cyc(40);

        check("snap_queue_empty", exp_snap.size(), 32'd0);
        check("byte_queue_empty", exp_bytes.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
